// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic cells (adder, subtractor, multiplier).
package serial_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit counter width for a WIDTH-bit serial operation; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit combinational full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, operands shifted LSB-first.
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] N_LAST = CW'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] xr_reg;
  logic [WIDTH-1:0] yr_reg;
  logic [WIDTH-1:0] s_reg;
  logic [CW-1:0]    n_reg;
  logic             c_reg;
  logic             c_out_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             fa_sum;
  logic             fa_cout;
  logic             accept;

  full_adder u_fa (
    .a    (xr_reg[0]),
    .b    (yr_reg[0]),
    .cin  (c_reg),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // A start is honoured in IDLE and also in DONE, which gives back-to-back operation.
  assign accept = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      xr_reg    <= '0;
      yr_reg    <= '0;
      s_reg     <= '0;
      n_reg     <= '0;
      c_reg     <= 1'b0;
      c_out_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else if (accept) begin
      state_reg <= ST_ADD;
      xr_reg    <= x;
      yr_reg    <= y;
      s_reg     <= '0;
      n_reg     <= '0;
      c_reg     <= 1'b0;
      busy_reg  <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_ADD: begin
          xr_reg <= xr_reg >> 1;
          yr_reg <= yr_reg >> 1;
          s_reg  <= {fa_sum, s_reg[WIDTH-1:1]};
          c_reg  <= fa_cout;
          n_reg  <= n_reg + CW'(1);
          if (n_reg == N_LAST) begin
            state_reg <= ST_DONE;
            c_out_reg <= fa_cout;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_reg;
  assign done  = done_reg;
  assign s     = s_reg;
  assign c_out = c_out_reg;

endmodule
